// File: rtl/alu_exec_unit.sv
// Multi-cycle integer execute unit: single-cycle logic/arith/compare ops,
// bit-serial shifts, valid/ready handshakes on request and result sides.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] SEL_AND  = 4'b0000;
    localparam logic [3:0] SEL_OR   = 4'b0001;
    localparam logic [3:0] SEL_ADD  = 4'b0010;
    localparam logic [3:0] SEL_XOR  = 4'b0011;
    localparam logic [3:0] SEL_SLL  = 4'b0100;
    localparam logic [3:0] SEL_SRL  = 4'b0101;
    localparam logic [3:0] SEL_SUB  = 4'b0110;
    localparam logic [3:0] SEL_SRA  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_SLTU = 4'b1001;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   cnt;
    logic [SHW-1:0]   shamt;
    logic [1:0]       shift_op;
    logic             accept;
    logic             is_shift;

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign shamt    = b[SHW-1:0];
    assign is_shift = (sel == SEL_SLL) || (sel == SEL_SRL) || (sel == SEL_SRA);

    // Single-cycle operations; shift codes are handled by the serial path.
    always_comb begin
        alu_res = '0;
        case (sel)
            SEL_AND:  alu_res = a & b;
            SEL_OR:   alu_res = a | b;
            SEL_ADD:  alu_res = a + b;
            SEL_SUB:  alu_res = a - b;
            SEL_XOR:  alu_res = a ^ b;
            SEL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            SEL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default:  alu_res = '0;
        endcase
    end

    // One-bit step of the working register; shift_op holds sel[1:0] of the shift.
    always_comb begin
        shifted = '0;
        case (shift_op)
            2'b00:   shifted = {work[WIDTH-2:0], 1'b0};
            2'b01:   shifted = {1'b0, work[WIDTH-1:1]};
            default: shifted = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) next_state = (is_shift && (shamt != '0)) ? SHIFT : DONE;
            end
            SHIFT: begin
                if (cnt == SHW'(1)) next_state = DONE;
            end
            DONE: begin
                if (out_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Datapath: result/zero are written only when an operation completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            cnt       <= '0;
            work      <= '0;
            shift_op  <= '0;
        end else begin
            out_valid <= (next_state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!is_shift) begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                        end else if (shamt == '0) begin
                            result <= a;
                            zero   <= (a == '0);
                        end else begin
                            work     <= a;
                            cnt      <= shamt;
                            shift_op <= sel[1:0];
                        end
                    end
                end
                SHIFT: begin
                    work <= shifted;
                    cnt  <= cnt - SHW'(1);
                    if (cnt == SHW'(1)) begin
                        result <= shifted;
                        zero   <= (shifted == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed ops with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  sel;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int acc   = 0;
    bit rnd   = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference semantics written directly from the operation definitions.
    function automatic logic [31:0] model(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
        int unsigned sh;
        sh = y[4:0];
        case (s)
            4'd0: return x & y;
            4'd1: return x | y;
            4'd2: return x + y;
            4'd6: return x - y;
            4'd3: return x ^ y;
            4'd4: return x << sh;
            4'd5: return x >> sh;
            4'd7: return $signed(x) >>> sh;
            4'd8: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'd9: return (x < y) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int lat(input logic [3:0] s, input logic [31:0] y);
        if ((s == 4'd4 || s == 4'd5 || s == 4'd7) && y[4:0] != 5'd0) return int'(y[4:0]) + 1;
        return 1;
    endfunction

    // Per-cycle model of the handshake and result stream.
    bit          m_busy = 0;
    bit          m_after_rst = 0;
    int          m_due = 0;
    logic [31:0] m_res = '0;

    always @(negedge clk) begin
        logic ev;
        logic er;
        ev = m_busy && (cyc >= m_due);
        er = !m_busy && !rst;
        chk("out_valid", 32'(out_valid), 32'(ev));
        chk("in_ready", 32'(in_ready), 32'(er));
        if (ev) begin
            chk("result", result, m_res);
            chk("zero", 32'(zero), 32'(m_res == 32'd0));
        end
        if (m_after_rst) begin
            chk("rst_result", result, 32'd0);
            chk("rst_zero", 32'(zero), 32'd0);
        end
        m_after_rst = rst;
        if (rst) begin
            m_busy = 0;
        end else if (in_valid && er) begin
            m_busy = 1;
            m_res  = model(sel, a, b);
            m_due  = cyc + lat(sel, b);
        end else if (ev && out_ready) begin
            m_busy = 0;
        end
    end

    // Entered just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [3:0] s, input logic [31:0] x, input logic [31:0] y);
        sel = s; a = x; b = y; in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom % 4) != 0;
        end
        chk("issue_timeout", 32'd1, 32'd0);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [31:0] exp, input int exp_lat);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (out_valid) begin
                chk(name, result, exp);
                chk({name, "_zero"}, 32'(zero), 32'(exp == 32'd0));
                chk({name, "_lat"}, 32'(cyc - acc), 32'(exp_lat));
                @(posedge clk); #1;
                return;
            end
        end
        chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        issue(4'b0010, 32'h7FFF_FFFF, 32'd1);   wait_result("add",   32'h8000_0000, 1);
        issue(4'b0110, 32'd5, 32'd5);           wait_result("sub",   32'h0000_0000, 1);
        issue(4'b0111, 32'h8000_0000, 32'h104); wait_result("sra",   32'hF800_0000, 5);
        issue(4'b0101, 32'h8000_0000, 32'h104); wait_result("srl",   32'h0800_0000, 5);
        issue(4'b0100, 32'd1, 32'd31);          wait_result("sll31", 32'h8000_0000, 32);
        issue(4'b0100, 32'hDEAD_BEEF, 32'd0);   wait_result("sll0",  32'hDEAD_BEEF, 1);
        issue(4'b1000, 32'hFFFF_FFFF, 32'd1);   wait_result("slt",   32'd1, 1);
        issue(4'b1001, 32'hFFFF_FFFF, 32'd1);   wait_result("sltu",  32'd0, 1);
        issue(4'b1111, 32'h1234_5678, 32'h9);   wait_result("illegal", 32'd0, 1);

        // Backpressure: result held, new requests ignored while DONE.
        out_ready = 1'b0;
        issue(4'b0011, 32'h0F0F_0F0F, 32'hFFFF_0000);
        for (int i = 0; i < 10; i++) begin
            a = $urandom; b = $urandom; sel = 4'($urandom); in_valid = 1'b1;
            @(negedge clk);
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", result, 32'hF0F0_0F0F);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_drop_valid", 32'(out_valid), 32'd0);
        chk("bp_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Reset in the middle of a serial shift.
        issue(4'b0100, 32'h0000_0001, 32'd20);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_result", result, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        issue(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00); wait_result("and", 32'hF000_F000, 1);

        // Randomized traffic with random backpressure; the monitor checks it all.
        rnd = 1;
        for (int n = 0; n < 200; n++) begin
            logic [3:0]  s;
            logic [31:0] y;
            s = 4'($urandom);
            if ($urandom % 3 == 0) s = 4'b0100 | 4'($urandom % 4);
            y = $urandom;
            if ($urandom % 2 == 0) y[4:0] = 5'($urandom % 6);
            issue(s, $urandom, y);
            repeat ($urandom % 3) begin
                @(posedge clk); #1;
                out_ready = ($urandom % 4) != 0;
            end
        end
        rnd = 0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        @(negedge clk);
        chk("drained_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
